// File: rtl/mem_access_ctrl.sv
// Two-port (fetch / load-store) arbiter and MAR/RAM/MDR strobe sequencer.
// Moore FSM: every strobe and done pulse is decoded from registered state.
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mar_bus,
  output logic              MARin,
  output logic              read,
  output logic              write,
  output logic              MDRin,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mdr_q,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MAR     = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // ACCESS lasts RAM_LAT cycles; a latency of 0 is treated as 1.
  localparam logic [2:0] LAT_M1 = (RAM_LAT <= 1) ? 3'd0 : 3'(RAM_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_ls_q, owner_ls_d;
  logic              last_ls_q, last_ls_d;
  logic              grant_ls;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_ls_q <= 1'b0;
      last_ls_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      owner_ls_q <= owner_ls_d;
      last_ls_q  <= last_ls_d;
    end
  end

  // LS wins a tie unless it won the previous grant.
  assign grant_ls = ls_req & (~if_req | ~last_ls_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    owner_ls_d = owner_ls_q;
    last_ls_d  = last_ls_q;
    case (state_q)
      S_IDLE: begin
        if (if_req || ls_req) begin
          state_d    = S_MAR;
          owner_ls_d = grant_ls;
          last_ls_d  = grant_ls;
          addr_d     = grant_ls ? ls_addr : if_addr;
          we_d       = grant_ls & ls_we;
          wdata_d    = grant_ls ? ls_wdata : '0;
        end
      end
      S_MAR: begin
        if (we_q) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_ACCESS;
          cnt_d   = LAT_M1;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 3'd0) state_d = S_CAPTURE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_CAPTURE: state_d = S_DONE;
      S_WRITE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MARin   = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    MDRin   = 1'b0;
    if_done = 1'b0;
    ls_done = 1'b0;
    case (state_q)
      S_MAR:     MARin = 1'b1;
      S_ACCESS:  read  = 1'b1;
      S_CAPTURE: begin
        read  = 1'b1;
        MDRin = 1'b1;
      end
      S_WRITE:   write = 1'b1;
      S_DONE: begin
        if_done = ~owner_ls_q;
        ls_done = owner_ls_q;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign mar_bus   = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = mdr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance at RAM_LAT=1, one at RAM_LAT=3.
module tb_mem_access_ctrl;

  logic        clock, clear;
  logic        if_req, ls_req, ls_we, if_req3;
  logic [8:0]  if_addr, ls_addr;
  logic [31:0] ls_wdata, rd_val;

  logic        if_done, ls_done, busy, MARin, read, write, MDRin;
  logic [31:0] rdata, mem_wdata, mdr_q;
  logic [8:0]  mar_bus;
  logic [2:0]  dbg_state;

  logic        if_done3, ls_done3, busy3, MARin3, read3, write3, MDRin3;
  logic [31:0] rdata3, mem_wdata3, mdr_q3;
  logic [8:0]  mar_bus3;
  logic [2:0]  dbg_state3;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(1)) dut (
    .clock(clock), .clear(clear),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done(ls_done), .rdata(rdata), .busy(busy), .mar_bus(mar_bus),
    .MARin(MARin), .read(read), .write(write), .MDRin(MDRin),
    .mem_wdata(mem_wdata), .mdr_q(mdr_q), .dbg_state(dbg_state)
  );

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(3)) dut3 (
    .clock(clock), .clear(clear),
    .if_req(if_req3), .if_addr(if_addr), .if_done(if_done3),
    .ls_req(1'b0), .ls_we(1'b0), .ls_addr(9'd0), .ls_wdata(32'd0),
    .ls_done(ls_done3), .rdata(rdata3), .busy(busy3), .mar_bus(mar_bus3),
    .MARin(MARin3), .read(read3), .write(write3), .MDRin(MDRin3),
    .mem_wdata(mem_wdata3), .mdr_q(mdr_q3), .dbg_state(dbg_state3)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // MDR model: captures the RAM word on MDRin
  initial begin
    mdr_q  = '0;
    mdr_q3 = '0;
  end
  always @(posedge clock) begin
    if (MDRin)  mdr_q  <= rd_val;
    if (MDRin3) mdr_q3 <= rd_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    repeat (2) tick();
    clear = 1'b1;
    tick();
  endtask

  initial begin
    clear = 1'b0; if_req = 0; ls_req = 0; ls_we = 0; if_req3 = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; rd_val = 32'hDEADBEEF;
    tick();
    // reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_strobes", {28'd0, MARin, read, write, MDRin}, 0);
    check("rst_done", {30'd0, if_done, ls_done}, 0);
    check("rst_mar_bus", 32'(mar_bus), 0);
    check("rst_mem_wdata", mem_wdata, 0);
    clear = 1'b1;
    tick();

    // 1: fetch read, RAM_LAT=1
    if_req = 1; if_addr = 9'h01F;
    tick(); // cycle 1
    if_req = 0;
    check("t1_c1_marin", 32'(MARin), 1);
    check("t1_c1_mar_bus", 32'(mar_bus), 32'h01F);
    check("t1_c1_read", 32'(read), 0);
    tick(); // cycle 2
    check("t1_c2_read_mdrin", {30'd0, read, MDRin}, 32'b10);
    tick(); // cycle 3
    check("t1_c3_read_mdrin", {30'd0, read, MDRin}, 32'b11);
    tick(); // cycle 4
    check("t1_c4_done", {30'd0, if_done, ls_done}, 32'b10);
    check("t1_c4_rdata", rdata, 32'hDEADBEEF);
    tick(); // cycle 5
    check("t1_c5_idle", {30'd0, busy, if_done}, 0);

    // 2: store
    ls_req = 1; ls_we = 1; ls_addr = 9'h1FF; ls_wdata = 32'h12345678;
    tick();
    ls_req = 0;
    check("t2_c1_marin", 32'(MARin), 1);
    check("t2_c1_mar_bus", 32'(mar_bus), 32'h1FF);
    check("t2_c1_rd_mdr", {30'd0, read, MDRin}, 0);
    tick();
    check("t2_c2_write", {29'd0, write, read, MDRin}, 32'b100);
    check("t2_c2_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    check("t2_c3_done", {29'd0, ls_done, if_done, read}, 32'b100);
    tick();
    check("t2_c4_idle", {30'd0, busy, ls_done}, 0);

    // 3: both requests held from reset -> LS, IF, LS, IF
    do_reset();
    ls_we = 0; ls_addr = 9'h0B0; if_addr = 9'h0A0;
    if_req = 1; ls_req = 1;
    for (int t = 0; t < 4; t++) begin
      logic exp_ls;
      exp_ls = (t % 2 == 0);
      tick(); // cycle 1
      check("t3_marin", 32'(MARin), 1);
      check("t3_mar_bus", 32'(mar_bus), exp_ls ? 32'h0B0 : 32'h0A0);
      for (int c = 2; c <= 3; c++) begin
        tick();
        check("t3_no_done", {30'd0, if_done, ls_done}, 0);
        check("t3_rw_excl", {30'd0, read, write}, 32'b10);
      end
      tick(); // cycle 4
      check("t3_done", {30'd0, if_done, ls_done}, exp_ls ? 32'b01 : 32'b10);
      tick(); // cycle 5: mandatory IDLE
      check("t3_idle_gap", {29'd0, busy, if_done, ls_done}, 0);
    end
    if_req = 0; ls_req = 0;
    tick();

    // 4: RAM_LAT=3 single read on second instance
    if_req3 = 1; if_addr = 9'h033; rd_val = 32'hCAFEF00D;
    tick();
    if_req3 = 0;
    check("t4_c1_marin", 32'(MARin3), 1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("t4_read", 32'(read3), 1);
      check("t4_mdrin", 32'(MDRin3), (c == 5) ? 1 : 0);
      check("t4_no_done", 32'(if_done3), 0);
    end
    tick(); // cycle 6
    check("t4_c6_done", {30'd0, if_done3, read3}, 32'b10);
    check("t4_c6_rdata", rdata3, 32'hCAFEF00D);
    tick();
    check("t4_c7_idle", 32'(busy3), 0);

    // 5: address change after grant is ignored
    ls_req = 1; ls_we = 0; ls_addr = 9'h010;
    tick(); // cycle 1
    ls_req = 0; ls_addr = 9'h0AA;
    for (int c = 1; c <= 4; c++) begin
      check("t5_mar_bus", 32'(mar_bus), 32'h010);
      if (c < 4) tick();
    end
    check("t5_done", 32'(ls_done), 1);
    tick();

    // 6: async clear during ACCESS
    if_req = 1; if_addr = 9'h055;
    tick(); // cycle 1
    if_req = 0;
    tick(); // cycle 2: ACCESS
    check("t6_in_access", {30'd0, read, busy}, 32'b11);
    #3 clear = 1'b0;
    #1;
    check("t6_async_clear", {26'd0, busy, MARin, read, write, MDRin, if_done}, 0);
    #2 clear = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t6_stay_idle", {29'd0, busy, if_done, ls_done}, 0);
    end
    if_req = 1; ls_req = 1; ls_we = 0; ls_addr = 9'h0C0; if_addr = 9'h0D0;
    tick();
    if_req = 0; ls_req = 0;
    check("t6_grant_ls", 32'(mar_bus), 32'h0C0);
    repeat (3) tick();
    check("t6_ls_done", {30'd0, if_done, ls_done}, 32'b01);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequencer and two-port arbiter for the MAR/RAM/MDR memory subsystem. It accepts word requests from an instruction-fetch port (read-only) and a load/store port (read/write). It drives the MAR load, RAM read/write and MDR load strobes in the correct order, and signals completion to the granted requester. It sits between the control unit's fetch and execute logic and the memory subsystem.

Parameters:
ADDR_W, 9, RAM word-address width (512 words)
DATA_W, 32, data word width
RAM_LAT, 1, cycles read stays asserted before MDR capture (1..7)

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-low reset
if_req  in  1  fetch read request, level, sampled only in IDLE
if_addr  in  ADDR_W  fetch word address
if_done  out  1  one-cycle pulse: fetch transaction complete
ls_req  in  1  load/store request, level, sampled only in IDLE
ls_we  in  1  1 = write, 0 = read
ls_addr  in  ADDR_W  load/store word address
ls_wdata  in  DATA_W  store data
ls_done  out  1  one-cycle pulse: load/store complete
rdata  out  DATA_W  read result, continuous copy of mdr_q, valid in the done cycle of a read
busy  out  1  1 in any state other than IDLE
mar_bus  out  ADDR_W  address driven to MAR input, latched at grant
MARin  out  1  MAR load strobe
read  out  1  RAM read / MDR read-select
write  out  1  RAM write strobe
MDRin  out  1  MDR load strobe
mem_wdata  out  DATA_W  write data to RAM, latched at grant
mdr_q  in  DATA_W  MDR output

Behaviour:
- Reset (clear=0, async): state IDLE; MARin, read, write, MDRin, if_done, ls_done, busy = 0; mar_bus, mem_wdata, the latched we bit and the latched owner = 0; last_grant = IF. A transaction in progress is abandoned with no done pulse.
- Moore FSM; all strobes and done outputs are decoded from registered state only.
- States and outputs:
  - IDLE: all strobes 0.
  - MAR: MARin=1.
  - ACCESS: read=1. Held for RAM_LAT cycles by a 3-bit counter, reloaded on entry.
  - CAPTURE: read=1, MDRin=1.
  - WRITE: write=1.
  - DONE: if_done or ls_done =1 for the latched owner.
- Read path: IDLE -> MAR -> ACCESS(xRAM_LAT) -> CAPTURE -> DONE -> IDLE.
- Write path: IDLE -> MAR -> WRITE -> DONE -> IDLE.
- Latency, with grant at edge 0: MARin in cycle 1.
  - Read: read in cycles 2..RAM_LAT+2, MDRin in cycle RAM_LAT+2, done in cycle RAM_LAT+3.
  - Write: write in cycle 2, done in cycle 3.
- Grant happens on the IDLE edge when any request is high.
  - Address, ls_we (forced 0 for IF), wdata and owner are latched at grant.
  - Input changes after grant are ignored.
- Arbitration:
  - Only one request high: it wins.
  - Both high: LS wins unless last_grant=LS, in which case IF wins (alternating).
  - last_grant updates at each grant.
- Requester drops req mid-transaction: the transaction still completes and done still pulses.
- Request held high through DONE: re-arbitrated in the following IDLE cycle. There is a minimum of one IDLE cycle between transactions.
- read and write are never 1 together. MDRin only occurs with read=1.
- RAM_LAT=0 is illegal and is treated as 1.

Test Plan:
1. RAM_LAT=1; if_req with if_addr=0x01F; mdr_q model returns 0xDEADBEEF after MDRin -> mar_bus=0x01F with MARin in cycle 1; read in cycles 2-3; MDRin in cycle 3; if_done in cycle 4 with rdata=0xDEADBEEF; ls_done stays 0.
2. ls_req, ls_we=1, ls_addr=0x1FF, ls_wdata=0x12345678 -> MARin in cycle 1; write in cycle 2 with mem_wdata=0x12345678; ls_done in cycle 3; read and MDRin never 1.
3. if_req and ls_req both held high for 4 transactions from reset -> grant order LS, IF, LS, IF; exactly one done pulse per transaction; one IDLE cycle between transactions.
4. RAM_LAT=3, single read -> read high in cycles 2-5; MDRin only in cycle 5; done in cycle 6.
5. ls_addr changes from 0x010 to 0x0AA one cycle after grant -> mar_bus remains 0x010 through done.
6. clear pulsed low during ACCESS -> read, busy and all strobes go to 0 without waiting for a clock edge; no done pulse; after release with no request, stays IDLE; next dual request is granted to LS.
